demux_serial_driver: RTL and testbench

Upstream feeder for the 1-to-4 gate-level demultiplexer. It accepts parallel words tagged with a 2-bit destination over a valid/ready handshake. Each word is serialized MSB-first onto the demux data input `x`, with the demux select `s` held at the destination for the whole word. A one-cycle idle gap follows every word so that the demux outputs return low between words.

---
 rtl/demux_serial_driver.sv | 110 +++++++++++
 tb/tb_demux_serial_driver.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/demux_serial_driver.sv
// Serializes valid/ready words MSB-first onto a 1-to-4 demux (x, s).
// Each word is followed by a one-cycle gap with x=0 and a done pulse.
module demux_serial_driver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_dest,
  output logic             x,
  output logic [1:0]       s,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             x_q, x_d;
  logic [1:0]       s_q, s_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    s_d     = s_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        if (in_valid && ready_q) begin
          state_d = SHIFT;
          shreg_d = in_data;
          s_d     = in_dest;
          x_d     = in_data[WIDTH-1];
          cnt_d   = CW'(WIDTH - 1);
          ready_d = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      SHIFT: begin
        // The counter holds how many bits remain after the one now on x.
        if (cnt_q != '0) begin
          shreg_d = shreg_q << 1;
          x_d     = shreg_d[WIDTH-1];
          cnt_d   = cnt_q - CW'(1);
        end else begin
          state_d = GAP;
          x_d     = 1'b0;
          done_d  = 1'b1;
        end
      end
      GAP: begin
        state_d = IDLE;
        x_d     = 1'b0;
        done_d  = 1'b0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        x_d     = 1'b0;
        done_d  = 1'b0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      x_q     <= 1'b0;
      s_q     <= 2'b00;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      s_q     <= s_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign in_ready = ready_q;
  assign x        = x_q;
  assign s        = s_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_demux_serial_driver.sv
// Self-checking bench: vector table, directed corner cases and random traffic
// checked against a timing-based reference model; plus a WIDTH=1 instance.
module tb_demux_serial_driver;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [1:0]   in_dest = 2'd0;
  logic         x, busy, done;
  logic [1:0]   s;

  logic         in_valid1 = 1'b0;
  logic         in_ready1;
  logic [0:0]   in_data1 = 1'b0;
  logic [1:0]   in_dest1 = 2'd0;
  logic         x1, busy1, done1;
  logic [1:0]   s1;

  demux_serial_driver #(.WIDTH(W)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dest(in_dest), .x(x), .s(s), .busy(busy), .done(done)
  );

  demux_serial_driver #(.WIDTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .in_dest(in_dest1), .x(x1), .s(s1), .busy(busy1), .done(done1)
  );

  // Output vectors are packed as {x, s[1:0], in_ready, busy, done}.
  typedef struct {
    logic         rst;
    logic         valid;
    logic [W-1:0] data;
    logic [1:0]   dest;
    logic [5:0]   exp;
  } vec_t;
  vec_t vecs[13];

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  bit accepted;

  // Reference model: cycles elapsed since acceptance (-1 when idle).
  int           m_phase = -1;
  logic [W-1:0] m_data  = '0;
  logic [1:0]   m_s     = 2'd0;

  function automatic logic [5:0] model_out();
    if (m_phase < 0)       return {1'b0, m_s, 1'b1, 1'b0, 1'b0};
    else if (m_phase <= W) return {m_data[W-m_phase], m_s, 1'b0, 1'b1, 1'b0};
    else                   return {1'b0, m_s, 1'b0, 1'b1, 1'b1};
  endfunction

  function automatic logic [5:0] dut_out();
    return {x, s, in_ready, busy, done};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: x/s/rdy/busy/done got %b required %b", name, cycle, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [W-1:0] d,
                      input logic [1:0] ds, input string name);
    reset    = r;
    in_valid = v;
    in_data  = d;
    in_dest  = ds;
    accepted = !r && v && (in_ready === 1'b1);
    if (accepted) $display("cycle %0d: accept data=%h dest=%0d (%s)", cycle, d, ds, name);
    if (r) begin
      m_phase = -1;
      m_s     = 2'd0;
    end else if (m_phase < 0) begin
      if (v) begin
        m_phase = 1;
        m_data  = d;
        m_s     = ds;
      end
    end else if (m_phase == W + 1) begin
      m_phase = -1;
    end else begin
      m_phase++;
    end
    @(posedge clk);
    @(negedge clk);
    cycle++;
    check(name, dut_out(), model_out());
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 2'd0, "idle");
  endtask

  int first_acc, second_acc, waited;
  logic [W-1:0] rd;
  logic [1:0]   rdst;
  logic         rv, rr;

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 8'hFF, 2'd3, 6'b000100};
    vecs[1]  = '{1'b1, 1'b1, 8'hFF, 2'd3, 6'b000100};
    vecs[2]  = '{1'b1, 1'b1, 8'hFF, 2'd3, 6'b000100};
    vecs[3]  = '{1'b0, 1'b1, 8'hA5, 2'd2, 6'b110010};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 2'd0, 6'b010010};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 2'd0, 6'b110010};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 2'd0, 6'b010010};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 2'd0, 6'b010010};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 2'd0, 6'b110010};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 2'd0, 6'b010010};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 2'd0, 6'b110010};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 2'd0, 6'b010011};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 2'd0, 6'b010100};

    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].dest, "vec_model");
      check($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
    end
    idle_steps(2);

    // Back-to-back: valid held, new word presented right after first acceptance.
    first_acc = -1;
    second_acc = -1;
    waited = 0;
    while (first_acc < 0 && waited < 20) begin
      step(1'b0, 1'b1, 8'hFF, 2'd0, "b2b_first");
      if (accepted) first_acc = cycle;
      waited++;
    end
    waited = 0;
    while (second_acc < 0 && waited < 20) begin
      step(1'b0, 1'b1, 8'h01, 2'd3, "b2b_second");
      if (accepted) second_acc = cycle;
      waited++;
    end
    n_checks++;
    if (first_acc < 0 || second_acc < 0 || second_acc - first_acc != W + 2) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d cycles required %0d", second_acc - first_acc, W + 2);
    end
    idle_steps(W + 2);

    // Busy stall: accept, then scramble inputs during SHIFT/GAP.
    step(1'b0, 1'b1, 8'h3C, 2'd1, "stall_acc");
    for (int i = 0; i < W + 1; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom), "stall");
    idle_steps(1);

    // Reset after the 4th bit of 8'hC3, then a fresh word.
    step(1'b0, 1'b1, 8'hC3, 2'd1, "rm_acc");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 2'd0, "rm_bits");
    step(1'b1, 1'b1, 8'h77, 2'd3, "rm_reset");
    step(1'b0, 1'b1, 8'h5A, 2'd2, "rm_next");
    idle_steps(W + 2);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rr   = ($urandom_range(0, 49) == 0);
      rv   = 1'($urandom_range(0, 1));
      rd   = 8'($urandom);
      rdst = 2'($urandom);
      step(rr, rv, rd, rdst, "random");
    end
    step(1'b1, 1'b0, '0, 2'd0, "final_reset");

    // WIDTH=1 instance.
    reset = 1'b0;
    in_valid = 1'b0;
    check("w1_idle", {x1, s1, in_ready1, busy1, done1}, 6'b000100);
    in_valid1 = 1'b1;
    in_data1  = 1'b1;
    in_dest1  = 2'd1;
    $display("cycle %0d: accept data=1 dest=1 (w1)", cycle);
    @(posedge clk); @(negedge clk);
    in_valid1 = 1'b0;
    in_data1  = 1'b0;
    in_dest1  = 2'd2;
    check("w1_shift", {x1, s1, in_ready1, busy1, done1}, 6'b101010);
    @(posedge clk); @(negedge clk);
    check("w1_gap", {x1, s1, in_ready1, busy1, done1}, 6'b001011);
    @(posedge clk); @(negedge clk);
    check("w1_ready", {x1, s1, in_ready1, busy1, done1}, 6'b001100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
